// File: rtl/imem_loader.sv
// Byte-stream program loader: parses a word-count header and writes the following
// little-endian 32-bit words into instruction memory, stalling the core meanwhile.
module imem_loader #(
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 128,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [7:0]        in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [31:0]       wdata,
    output logic              cpu_stall,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_IDLE, S_LEN_LO, S_LEN_HI, S_DATA, S_WRITE, S_DONE, S_ERR
    } state_t;

    localparam logic [15:0]       C_DEPTH = 16'(DEPTH);
    localparam logic [ADDR_W-1:0] C_BASE  = ADDR_W'(BASE_ADDR);

    state_t              r_state, w_next;
    logic [15:0]         r_len;
    logic [1:0]          r_byte_idx;
    logic [15:0]         r_word_idx;
    logic [ADDR_W-1:0]   r_waddr;
    logic [31:0]         r_wdata;
    logic                w_xfer;
    logic [15:0]         w_len_full;
    logic                w_start_ok;

    assign w_xfer     = in_valid & in_ready;
    assign w_len_full = {in_data, r_len[7:0]};
    assign w_start_ok = start & ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
    assign waddr      = r_waddr;
    assign wdata      = r_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        we        = 1'b0;
        cpu_stall = 1'b1;
        done      = 1'b0;
        error     = 1'b0;
        case (r_state)
            S_IDLE: begin
                cpu_stall = 1'b0;
                if (start) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                in_ready = 1'b1;
                if (w_xfer) w_next = S_LEN_HI;
            end
            S_LEN_HI: begin
                in_ready = 1'b1;
                if (w_xfer) begin
                    if (w_len_full == 16'd0)         w_next = S_DONE;
                    else if (w_len_full > C_DEPTH)   w_next = S_ERR;
                    else                             w_next = S_DATA;
                end
            end
            S_DATA: begin
                in_ready = 1'b1;
                if (w_xfer && r_byte_idx == 2'd3) w_next = S_WRITE;
            end
            S_WRITE: begin
                we = 1'b1;
                if (r_word_idx + 16'd1 == r_len) w_next = S_DONE;
                else                             w_next = S_DATA;
            end
            S_DONE: begin
                cpu_stall = 1'b0;
                done      = 1'b1;
                if (start) w_next = S_LEN_LO;
            end
            S_ERR: begin
                error = 1'b1;
                if (start) w_next = S_LEN_LO;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_len      <= '0;
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_waddr    <= C_BASE;
            r_wdata    <= '0;
        end else if (w_start_ok) begin
            r_len      <= '0;
            r_byte_idx <= '0;
            r_word_idx <= '0;
            r_waddr    <= C_BASE;
            r_wdata    <= '0;
        end else begin
            case (r_state)
                S_LEN_LO: if (w_xfer) r_len[7:0]  <= in_data;
                S_LEN_HI: if (w_xfer) r_len[15:8] <= in_data;
                S_DATA: if (w_xfer) begin
                    // byte index wraps to 0 after the 4th byte, ready for the next word
                    r_wdata[8*r_byte_idx +: 8] <= in_data;
                    r_byte_idx                 <= r_byte_idx + 2'd1;
                end
                S_WRITE: begin
                    r_waddr    <= r_waddr + ADDR_W'(4);
                    r_word_idx <= r_word_idx + 16'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: two instances (BASE 0 and 256) share stimulus and are
// checked every cycle against a byte-count based model, plus literal end-of-test checks.
module tb_imem_loader;

    localparam int DEPTH = 128;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  in_data = 8'h00;
    logic        in_valid = 1'b0;

    logic        in_ready0, we0, stall0, done0, error0;
    logic [15:0] waddr0;
    logic [31:0] wdata0;
    logic        in_ready1, we1, stall1, done1, error1;
    logic [15:0] waddr1;
    logic [31:0] wdata1;

    int checks = 0;
    int errors = 0;

    imem_loader #(.ADDR_W(16), .DEPTH(DEPTH), .BASE_ADDR(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready0), .we(we0), .waddr(waddr0), .wdata(wdata0),
        .cpu_stall(stall0), .done(done0), .error(error0)
    );

    imem_loader #(.ADDR_W(16), .DEPTH(DEPTH), .BASE_ADDR(256)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready1), .we(we1), .waddr(waddr1), .wdata(wdata1),
        .cpu_stall(stall1), .done(done1), .error(error1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Model: mode 0 idle, 1 loading, 2 done, 3 error; progress tracked as bytes accepted
    int          m_mode = 0;
    int          m_cnt = 0;
    int          m_widx = 0;
    bit          m_wpend = 0;
    logic [15:0] m_n = 0;
    logic [31:0] m_word = 0;
    logic [15:0] act_addr0[$];
    logic [15:0] act_addr1[$];
    logic [31:0] act_data[$];

    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                m_mode = 0; m_cnt = 0; m_widx = 0; m_wpend = 0;
            end
            chk("in_ready0", in_ready0, (m_mode == 1) && !m_wpend);
            chk("in_ready1", in_ready1, (m_mode == 1) && !m_wpend);
            chk("we0", we0, m_wpend);
            chk("we1", we1, m_wpend);
            chk("stall0", stall0, (m_mode == 1) || (m_mode == 3));
            chk("stall1", stall1, (m_mode == 1) || (m_mode == 3));
            chk("done0", done0, m_mode == 2);
            chk("done1", done1, m_mode == 2);
            chk("error0", error0, m_mode == 3);
            chk("error1", error1, m_mode == 3);
            chk("waddr0", waddr0, 16'(4 * m_widx));
            chk("waddr1", waddr1, 16'(256 + 4 * m_widx));
            if (m_wpend) begin
                chk("wdata0", wdata0, m_word);
                chk("wdata1", wdata1, m_word);
            end
            if (we0) begin
                act_addr0.push_back(waddr0);
                act_addr1.push_back(waddr1);
                act_data.push_back(wdata0);
            end
            if (!rst) begin
                if (m_mode != 1) begin
                    if (start) begin
                        m_mode = 1; m_cnt = 0; m_widx = 0; m_wpend = 0;
                    end
                end else if (m_wpend) begin
                    m_wpend = 0;
                    m_widx++;
                    if (m_widx == int'(m_n)) m_mode = 2;
                end else if (in_valid) begin
                    m_cnt++;
                    if (m_cnt == 1) m_n[7:0] = in_data;
                    else if (m_cnt == 2) begin
                        m_n[15:8] = in_data;
                        if (m_n == 0)              m_mode = 2;
                        else if (int'(m_n) > DEPTH) m_mode = 3;
                    end else begin
                        m_word[8*((m_cnt-3)%4) +: 8] = in_data;
                        if ((m_cnt - 2) % 4 == 0) m_wpend = 1;
                    end
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok = 0;
        int n = 0;
        in_valid = 1'b0;
        for (int i = 0; i < gap; i++) begin
            in_data = 8'($urandom);
            tick();
        end
        in_valid = 1'b1;
        in_data  = b;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = in_ready0;
            tick();
            n++;
        end
        in_valid = 1'b0;
        if (!ok) chk("byte_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic send_word(input logic [31:0] w, input int maxgap);
        for (int k = 0; k < 4; k++) send_byte(w[8*k +: 8], $urandom_range(maxgap, 0));
    endtask

    task automatic wait_end();
        int n = 0;
        while (!(done0 || error0) && n < 1000) begin tick(); n++; end
        if (!(done0 || error0)) chk("end_timeout", 32'd0, 32'd1);
    endtask

    task automatic clear_log();
        act_addr0.delete(); act_addr1.delete(); act_data.delete();
    endtask

    initial begin
        logic [31:0] w;
        tick(); tick();
        chk("rst_in_ready", in_ready0, 0);
        chk("rst_we", we0, 0);
        chk("rst_waddr0", waddr0, 0);
        chk("rst_waddr1", waddr1, 256);
        chk("rst_wdata", wdata0, 0);
        chk("rst_stall", stall0, 0);
        chk("rst_done", done0, 0);
        chk("rst_error", error0, 0);
        rst = 1'b0;
        tick();

        // 1) two-word program
        clear_log();
        pulse_start();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        send_word(32'h00300413, 0);
        send_word(32'h00100493, 0);
        wait_end();
        chk("t1_nwrites", act_data.size(), 2);
        if (act_data.size() == 2) begin
            chk("t1_a0", act_addr0[0], 16'h0000);
            chk("t1_d0", act_data[0], 32'h00300413);
            chk("t1_a1", act_addr0[1], 16'h0004);
            chk("t1_d1", act_data[1], 32'h00100493);
        end
        chk("t1_done", done0, 1);
        chk("t1_stall", stall0, 0);

        // 2) empty image
        clear_log();
        pulse_start();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        chk("t2_done", done0, 1);
        tick();
        chk("t2_nwrites", act_data.size(), 0);

        // 3) oversize header, then recovery
        clear_log();
        pulse_start();
        send_byte(8'h81, 1); send_byte(8'h00, 2);
        repeat (3) tick();
        chk("t3_error", error0, 1);
        chk("t3_stall", stall0, 1);
        chk("t3_nwrites", act_data.size(), 0);
        pulse_start();
        chk("t3_err_clr", error0, 0);
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_word(32'hCAFEF00D, 0);
        wait_end();
        chk("t3_rec_done", done0, 1);
        chk("t3_rec_n", act_data.size(), 1);

        // 4) one word with random valid gaps, several rounds
        for (int r = 0; r < 4; r++) begin
            clear_log();
            w = $urandom;
            pulse_start();
            send_byte(8'h01, $urandom_range(5, 0)); send_byte(8'h00, $urandom_range(5, 0));
            send_word(w, 5);
            wait_end();
            chk("t4_n", act_data.size(), 1);
            if (act_data.size() == 1) begin
                chk("t4_addr", act_addr0[0], 16'h0000);
                chk("t4_data", act_data[0], w);
            end
        end

        // 5) reset in the middle of a word
        clear_log();
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h11, 0); send_byte(8'h22, 0);
        rst = 1'b1;
        #1;
        chk("t5_ready", in_ready0, 0);
        chk("t5_we", we0, 0);
        chk("t5_waddr1", waddr1, 256);
        chk("t5_wdata", wdata0, 0);
        chk("t5_stall", stall0, 0);
        chk("t5_done", done0, 0);
        chk("t5_error", error0, 0);
        tick();
        rst = 1'b0;
        tick();
        pulse_start();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_word(32'h89ABCDEF, 1);
        wait_end();
        chk("t5_n", act_data.size(), 1);
        if (act_data.size() == 1) begin
            chk("t5_addr", act_addr0[0], 16'h0000);
            chk("t5_data", act_data[0], 32'h89ABCDEF);
        end

        // 6) full-depth image, with an ignored start pulse mid-load
        clear_log();
        pulse_start();
        send_byte(8'h80, 0); send_byte(8'h00, 0);
        for (int i = 0; i < DEPTH; i++) begin
            if (i == 60) pulse_start();
            send_word($urandom, (i % 16 == 0) ? 2 : 0);
        end
        wait_end();
        chk("t6_n", act_data.size(), DEPTH);
        if (act_data.size() == DEPTH) begin
            chk("t6_last_addr1", act_addr1[DEPTH-1], 16'd764);
            chk("t6_last_addr0", act_addr0[DEPTH-1], 16'd508);
        end
        chk("t6_done", done0, 1);
        chk("t6_stall", stall1, 0);

        tick(); tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
